// File: rtl/hps_frame_sequencer.sv
// rtl/hps_frame_sequencer.sv - HPS SPI frame sequencer: command/payload split, status readback, event pending mask
module hps_frame_sequencer #(
  parameter logic [7:0]  STATUS_ID = 8'h5A,
  parameter int          NREQ      = 8,
  parameter logic [15:0] CMD_ACK   = 16'h00FF,
  parameter int          IDXW      = 12
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [31:0]       gp_out,
  input  logic              io_strobe,
  output logic [15:0]       gp_in,
  input  logic [15:0]       resp_data,
  input  logic [NREQ-1:0]   req,
  output logic              frame_active,
  output logic [1:0]        frame_src,
  output logic              frame_end,
  output logic [15:0]       cmd,
  output logic              cmd_valid,
  output logic [15:0]       data_out,
  output logic              data_strobe,
  output logic [IDXW-1:0]   word_idx,
  output logic [NREQ-1:0]   pending,
  output logic              proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_en_s1, r_en_s2, r_en_prev;
  logic [2:0]        w_rise;
  logic [1:0]        r_src, w_new_src;
  logic              w_src_level;
  logic              w_open, w_close, w_cmd_acc, w_data_acc, w_perr, w_ack_clr;
  logic [IDXW-1:0]   r_idx, r_word_idx;
  logic [15:0]       r_cmd, r_data, r_gp_in;
  logic              r_cmd_valid, r_data_strobe, r_frame_end, r_proto_err;
  logic [NREQ-1:0]   r_pending;
  logic [7:0]        w_pend8;
  logic              w_unused_bits;

  assign w_unused_bits = ^{gp_out[31:21], gp_out[17:16]};

  // Enable bit order in the synchronizer: [2]=io, [1]=osd, [0]=fpga.
  assign w_rise = r_en_s2 & ~r_en_prev;

  always_comb begin
    w_new_src = 2'd0;
    if (w_rise[2])      w_new_src = 2'd1;
    else if (w_rise[1]) w_new_src = 2'd2;
    else if (w_rise[0]) w_new_src = 2'd3;
  end

  always_comb begin
    w_src_level = 1'b0;
    case (r_src)
      2'd1:    w_src_level = r_en_s2[2];
      2'd2:    w_src_level = r_en_s2[1];
      2'd3:    w_src_level = r_en_s2[0];
      default: w_src_level = 1'b0;
    endcase
  end

  always_comb begin
    w_pend8 = 8'h00;
    w_pend8[NREQ-1:0] = r_pending;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A strobe in the closing cycle still belongs to the frame being closed.
  always_comb begin
    w_state_nxt = r_state;
    w_open      = 1'b0;
    w_close     = 1'b0;
    w_cmd_acc   = 1'b0;
    w_data_acc  = 1'b0;
    w_perr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_rise) begin
          w_open = 1'b1;
          if (io_strobe) begin
            w_cmd_acc   = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_CMD;
          end
        end else if (io_strobe) begin
          w_perr = 1'b1;
        end
      end
      S_CMD: begin
        if (io_strobe) begin
          w_cmd_acc   = 1'b1;
          w_state_nxt = S_DATA;
        end
        if (!w_src_level) begin
          w_close     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (io_strobe) w_data_acc = 1'b1;
        if (!w_src_level) begin
          w_close     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ack_clr = w_data_acc && (r_cmd == CMD_ACK) && (r_idx == '0);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      // Sync chain and history start high so an enable held at reset release cannot open a frame.
      r_en_s1       <= 3'b111;
      r_en_s2       <= 3'b111;
      r_en_prev     <= 3'b111;
      r_src         <= 2'd0;
      r_cmd         <= 16'h0000;
      r_cmd_valid   <= 1'b0;
      r_data        <= 16'h0000;
      r_data_strobe <= 1'b0;
      r_idx         <= '0;
      r_word_idx    <= '0;
      r_frame_end   <= 1'b0;
      r_proto_err   <= 1'b0;
      r_pending     <= '0;
      r_gp_in       <= {STATUS_ID, 8'h00};
    end else begin
      r_en_s1       <= gp_out[20:18];
      r_en_s2       <= r_en_s1;
      r_en_prev     <= r_en_s2;
      r_cmd_valid   <= w_cmd_acc;
      r_data_strobe <= w_data_acc;
      r_frame_end   <= w_close;
      if (w_open) r_src <= w_new_src;
      if (w_cmd_acc) begin
        r_cmd <= gp_out[15:0];
        r_idx <= '0;
      end
      if (w_data_acc) begin
        r_data     <= gp_out[15:0];
        r_word_idx <= r_idx;
        if (r_idx != {IDXW{1'b1}}) r_idx <= r_idx + 1'b1;
      end
      if (w_perr) r_proto_err <= 1'b1;
      r_pending <= (r_pending & ~(w_ack_clr ? gp_out[NREQ-1:0] : '0)) | req;
      if (r_state == S_DATA) r_gp_in <= resp_data;
      else                   r_gp_in <= {STATUS_ID, w_pend8};
    end
  end

  assign gp_in        = r_gp_in;
  assign frame_active = (r_state != S_IDLE);
  assign frame_src    = r_src;
  assign frame_end    = r_frame_end;
  assign cmd          = r_cmd;
  assign cmd_valid    = r_cmd_valid;
  assign data_out     = r_data;
  assign data_strobe  = r_data_strobe;
  assign word_idx     = r_word_idx;
  assign pending      = r_pending;
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_hps_frame_sequencer.sv
// tb/tb_hps_frame_sequencer.sv - scoreboard bench for hps_frame_sequencer
module tb_hps_frame_sequencer;
  logic        sys_clk = 1'b0;
  logic        reset;
  logic [31:0] gp_out;
  logic        io_strobe;
  logic [15:0] gp_in;
  logic [15:0] resp_data;
  logic [7:0]  req;
  logic        frame_active;
  logic [1:0]  frame_src;
  logic        frame_end;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic [15:0] data_out;
  logic        data_strobe;
  logic [1:0]  word_idx;
  logic [7:0]  pending;
  logic        proto_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] q_cmd[$];
  logic [15:0] q_data[$];
  logic [1:0]  q_idx[$];
  int          q_fe_cyc[$];
  logic [1:0]  q_fe_src[$];

  hps_frame_sequencer #(.IDXW(2)) dut (
    .sys_clk(sys_clk), .reset(reset), .gp_out(gp_out), .io_strobe(io_strobe),
    .gp_in(gp_in), .resp_data(resp_data), .req(req),
    .frame_active(frame_active), .frame_src(frame_src), .frame_end(frame_end),
    .cmd(cmd), .cmd_valid(cmd_valid), .data_out(data_out), .data_strobe(data_strobe),
    .word_idx(word_idx), .pending(pending), .proto_err(proto_err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!reset) begin
      if (cmd_valid) begin
        if (q_cmd.size() == 0) chk("unexpected_cmd_valid", {16'h0, cmd}, 32'hFFFF_FFFF);
        else chk("cmd", {16'h0, cmd}, {16'h0, q_cmd.pop_front()});
      end
      if (data_strobe) begin
        if (q_data.size() == 0) chk("unexpected_data_strobe", {16'h0, data_out}, 32'hFFFF_FFFF);
        else begin
          chk("data_out", {16'h0, data_out}, {16'h0, q_data.pop_front()});
          chk("word_idx", {30'h0, word_idx}, {30'h0, q_idx.pop_front()});
        end
      end
      if (frame_end) begin
        if (q_fe_cyc.size() == 0) chk("unexpected_frame_end", cyc, 32'hFFFF_FFFF);
        else begin
          chk("frame_end_cycle", cyc, q_fe_cyc.pop_front());
          chk("frame_end_src", {30'h0, frame_src}, {30'h0, q_fe_src.pop_front()});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [15:0] w, input logic [7:0] r);
    gp_out[15:0] = w;
    io_strobe = 1'b1;
    req = r;
    tick(1);
    io_strobe = 1'b0;
    req = 8'h00;
    tick(2);
  endtask

  task automatic close_frame(input logic [2:0] en, input logic [1:0] src);
    gp_out[20:18] = en;
    q_fe_cyc.push_back(cyc + 3);
    q_fe_src.push_back(src);
    tick(5);
  endtask

  initial begin
    reset = 1'b1; gp_out = 32'h0; io_strobe = 1'b0; resp_data = 16'h0; req = 8'h00;
    tick(3);
    chk("rst_gp_in", {16'h0, gp_in}, 32'h5A00);
    chk("rst_pending", {24'h0, pending}, 32'h0);
    chk("rst_frame_active", {31'h0, frame_active}, 32'h0);
    chk("rst_cmd", {16'h0, cmd}, 32'h0);
    chk("rst_proto_err", {31'h0, proto_err}, 32'h0);
    chk("rst_frame_src", {30'h0, frame_src}, 32'h0);
    reset = 1'b0;
    tick(4);

    // basic io frame
    gp_out[20] = 1'b1;
    tick(2);
    chk("open_not_early", {31'h0, frame_active}, 32'h0);
    tick(1);
    chk("open_at_3", {31'h0, frame_active}, 32'h1);
    chk("src_io", {30'h0, frame_src}, 32'h1);
    q_cmd.push_back(16'h0021);  strobe(16'h0021, 8'h00);
    q_data.push_back(16'h1111); q_idx.push_back(2'd0); strobe(16'h1111, 8'h00);
    q_data.push_back(16'h2222); q_idx.push_back(2'd1); strobe(16'h2222, 8'h00);
    close_frame(3'b000, 2'd1);
    chk("closed", {31'h0, frame_active}, 32'h0);
    chk("cmd_hold", {16'h0, cmd}, 32'h0021);

    // pending and ack
    req = 8'h05;
    tick(1);
    req = 8'h00;
    chk("pending_t1", {24'h0, pending}, 32'h05);
    tick(1);
    chk("status_t2", {16'h0, gp_in}, 32'h5A05);
    resp_data = 16'hBEEF;
    gp_out[20:18] = 3'b100;
    tick(4);
    q_cmd.push_back(16'h00FF);  strobe(16'h00FF, 8'h00);
    q_data.push_back(16'h0001); q_idx.push_back(2'd0); strobe(16'h0001, 8'h00);
    chk("gp_in_resp", {16'h0, gp_in}, 32'hBEEF);
    q_data.push_back(16'h0004); q_idx.push_back(2'd1); strobe(16'h0004, 8'h00);
    chk("ack_idx1_noeffect", {24'h0, pending}, 32'h04);
    close_frame(3'b000, 2'd1);
    chk("pending_acked", {24'h0, pending}, 32'h04);
    chk("status_acked", {16'h0, gp_in}, 32'h5A04);
    gp_out[20:18] = 3'b100;
    tick(4);
    q_cmd.push_back(16'h00FF);  strobe(16'h00FF, 8'h00);
    q_data.push_back(16'h0001); q_idx.push_back(2'd0); strobe(16'h0001, 8'h01);
    close_frame(3'b000, 2'd1);
    chk("set_wins_clear", {24'h0, pending}, 32'h05);

    // osd + fpga together
    gp_out[20:18] = 3'b011;
    tick(4);
    chk("src_osd", {30'h0, frame_src}, 32'h2);
    q_cmd.push_back(16'h0033); strobe(16'h0033, 8'h00);
    gp_out[20:18] = 3'b010;
    tick(5);
    chk("fpga_fall_ignored", {31'h0, frame_active}, 32'h1);
    close_frame(3'b000, 2'd2);
    chk("osd_closed", {31'h0, frame_active}, 32'h0);

    // strobe outside a frame
    strobe(16'h1234, 8'h00);
    chk("proto_err_set", {31'h0, proto_err}, 32'h1);
    gp_out[20:18] = 3'b100;
    tick(4);
    q_cmd.push_back(16'h0042); strobe(16'h0042, 8'h00);
    close_frame(3'b000, 2'd1);
    chk("proto_err_sticky", {31'h0, proto_err}, 32'h1);

    // index saturation with IDXW=2
    gp_out[20:18] = 3'b100;
    tick(4);
    q_cmd.push_back(16'h0050); strobe(16'h0050, 8'h00);
    for (int i = 0; i < 6; i++) begin
      q_data.push_back(16'hA000 + 16'(i));
      q_idx.push_back((i > 3) ? 2'd3 : 2'(i));
      strobe(16'hA000 + 16'(i), 8'h00);
    end
    close_frame(3'b000, 2'd1);

    // reset mid-frame with io held high
    gp_out[20:18] = 3'b100;
    tick(4);
    q_cmd.push_back(16'h0060);  strobe(16'h0060, 8'h00);
    q_data.push_back(16'h6001); q_idx.push_back(2'd0); strobe(16'h6001, 8'h00);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("reset_idle", {31'h0, frame_active}, 32'h0);
    chk("reset_proto_clr", {31'h0, proto_err}, 32'h0);
    chk("reset_src", {30'h0, frame_src}, 32'h0);
    strobe(16'h7777, 8'h00);
    chk("held_en_no_frame", {31'h0, proto_err}, 32'h1);
    gp_out[20:18] = 3'b000;
    tick(4);
    gp_out[20:18] = 3'b100;
    tick(4);
    chk("reopen", {31'h0, frame_active}, 32'h1);
    q_cmd.push_back(16'h0070); strobe(16'h0070, 8'h00);
    close_frame(3'b000, 2'd1);

    chk("q_cmd_empty", q_cmd.size(), 0);
    chk("q_data_empty", q_data.size(), 0);
    chk("q_fe_empty", q_fe_cyc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hps_frame_sequencer.md
# hps_frame_sequencer

Frame-level controller behind the HPS SPI word interface. It watches the 32-bit `gp_out` bus and per-word `io_strobe` from the SPI slave wrapper. It splits each enable-delimited transfer into a command word followed by indexed payload words, and drives `gp_in` with a status word or client response data. It also arbitrates up to 8 core-side event requesters into a sticky pending mask that the HPS reads and acknowledges.

## Interface
- `STATUS_ID`, 8'h5A, core identifier placed in status word bits [15:8]
- `NREQ`, 8, number of event requesters (1..8)
- `CMD_ACK`, 16'h00FF, command whose payload word 0 clears pending bits
- `IDXW`, 12, payload word index width
- `sys_clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `gp_out` in 32: from SPI wrapper; [15:0] received word, [18] fpga_enable, [19] osd_enable, [20] io_enable
- `io_strobe` in 1: one-cycle pulse, new word on `gp_out[15:0]`
- `gp_in` out 16: word returned to HPS on the next transfer
- `resp_data` in 16: client response for the current payload position
- `req` in NREQ: event requests, level or pulse; each set cycle marks its bit pending
- `frame_active` out 1: frame open
- `frame_src` out 2: 0 none, 1 io, 2 osd, 3 fpga; latched at frame start
- `frame_end` out 1: one-cycle pulse on frame close
- `cmd` out 16: command word of current/last frame
- `cmd_valid` out 1: one-cycle pulse, `cmd` updated
- `data_out` out 16: payload word
- `data_strobe` out 1: one-cycle pulse, `data_out`/`word_idx` valid
- `word_idx` out IDXW: 0-based payload index of `data_out`
- `pending` out NREQ: sticky request mask
- `proto_err` out 1: sticky; strobe received outside a frame

## Operation
- Enables `gp_out[20:18]` pass through a 2-flop synchronizer. The source is chosen by priority io > osd > fpga.
- The previous-enable register resets to all ones. An enable already high at reset release does not open a frame until it has been seen low.
- States:
  - IDLE → CMD on a rising edge of any synced enable; latch `frame_src`, assert `frame_active`.
  - CMD → DATA on `io_strobe`: `cmd <= gp_out[15:0]`, `cmd_valid` pulses.
  - DATA: each `io_strobe` sets `data_out`, `word_idx`, and pulses `data_strobe`. The internal index increments and saturates at 2^IDXW−1. At saturation, further words repeat the max index.
  - CMD/DATA → IDLE when the latched source's synced enable falls; pulse `frame_end`, clear `frame_active`. `cmd` holds its value.
- A different enable rising mid-frame is ignored. After the frame closes, a new frame needs a fresh rising edge.
- `gp_in` is registered:
  - IDLE/CMD: status `{STATUS_ID, pending zero-extended to 8}`.
  - DATA: `resp_data`, sampled every cycle.
- Pending: `pending[i]` is set whenever `req[i]` is high. When `cmd == CMD_ACK` and payload word index 0 is strobed, `pending &= ~gp_out[NREQ-1:0]`. Set wins over clear on the same bit in the same cycle. Words at index ≥1 of CMD_ACK have no effect on `pending`.
- `proto_err` sets on `io_strobe` in IDLE; the word is dropped. It clears only on reset.

## Timing
- Reset values: `gp_in` = {STATUS_ID, 8'h00}, `pending` = 0, `cmd` = 0, `data_out` = 0, `word_idx` = 0, `frame_src` = 0, all pulses/flags = 0, state IDLE.
- Enable edge to `frame_active`/`frame_end`: 3 cycles (2 sync + 1 register).
- `io_strobe` at cycle T → `cmd_valid` or `data_strobe` at T+1, with outputs stable from T+1.
- `req[i]` at T → `pending[i]` at T+1 → status in `gp_in` at T+2.
- CMD→DATA switches the `gp_in` source at T+2 after the command strobe. This is in place before the wrapper's next data request, which follows a full 16-bit SPI word.
- A strobe at T with synced enable falling at T: the strobe is accepted as part of the frame, and `frame_end` pulses at T+1 together with its `data_strobe`/`cmd_valid`.
- A strobe arriving as the frame opens (IDLE → CMD transition cycle) is treated as the command.
- Reset mid-frame: immediate return to IDLE with no `frame_end` pulse. The enable must drop low and rise again to start a new frame.

## Test plan
- io_enable rise; strobes with 0x0021, 0x1111, 0x2222; io_enable fall → `cmd_valid` with `cmd`=0x0021; `data_strobe` with (0x1111, idx 0) and (0x2222, idx 1); `frame_src`=1; `frame_end` 3 cycles after the fall.
- req=8'h05 for 1 cycle, then read in IDLE → `gp_in`=0x5A05. Frame with CMD_ACK and payload 0x0001 → `pending`=0x04 and `gp_in`=0x5A04. Repeat with req[0] asserted in the ack cycle → bit 0 stays 1.
- osd_enable and fpga_enable rise together → `frame_src`=2. fpga_enable falls first → frame stays open; osd_enable falls → `frame_end`.
- Strobe with no enable → `proto_err`=1, no `cmd_valid`; `proto_err` is still 1 after a following valid frame.
- IDXW=2, 6 payload words → idx sequence 0,1,2,3,3,3.
- Assert reset mid-DATA with io_enable held high → IDLE, no frames on later strobes (`proto_err` sets). io_enable low then high → a new frame opens normally.
